// File: rtl/mshr_pkg.sv
// Shared definitions for the LSU miss-handling queue: default sizing and the
// miss-record field layout used by producer, queue and writeback decode.
package mshr_pkg;

    localparam int MSHR_DEPTH      = 8;
    localparam int MSHR_DATA_WIDTH = 74;
    localparam int MSHR_LAT_WIDTH  = 3;

    // Miss-record layout, LSB first; widths sum to MSHR_DATA_WIDTH.
    localparam int REC_SB_INFO_LSB   = 0;
    localparam int REC_SB_INFO_W     = 6;
    localparam int REC_MASK_LSB      = 6;
    localparam int REC_MASK_W        = 32;
    localparam int REC_WARP_ID_LSB   = 38;
    localparam int REC_WARP_ID_W     = 5;
    localparam int REC_WORD_ADDR_LSB = 43;
    localparam int REC_WORD_ADDR_W   = 4;
    localparam int REC_LINE_ADDR_LSB = 47;
    localparam int REC_LINE_ADDR_W   = 26;
    localparam int REC_IS_STORE_BIT  = 73;

endpackage

// File: rtl/mshr_lat_cnt.sv
// Per-entry valid flag and miss-latency countdown; zero flags that the
// entry's latency has fully elapsed.
module mshr_lat_cnt
    import mshr_pkg::*;
#(
    parameter int LAT_WIDTH = MSHR_LAT_WIDTH
) (
    input  logic                 clk,
    input  logic                 load,
    input  logic [LAT_WIDTH-1:0] lat,
    input  logic                 clear,
    output logic                 zero
);

    logic                 vld;
    logic [LAT_WIDTH-1:0] cnt;

    function automatic logic [LAT_WIDTH-1:0] dec_sat(input logic [LAT_WIDTH-1:0] v);
        return (v == '0) ? v : v - LAT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (clear) begin
            vld <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            vld <= 1'b1;
            cnt <= lat;
        end else if (vld) begin
            cnt <= dec_sat(cnt);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mshr_latency_queue.sv
// In-order miss queue with a per-entry latency countdown gating the head.
// Optional stall statistics counter enabled by MSHR_STALL_STATS_EN.
module mshr_latency_queue
    import mshr_pkg::*;
#(
    parameter int DEPTH      = MSHR_DEPTH,
    parameter int DATA_WIDTH = MSHR_DATA_WIDTH,
    parameter int LAT_WIDTH  = MSHR_LAT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic [LAT_WIDTH-1:0]    push_lat,
    output logic                    pop_valid,
    input  logic                    pop_ready,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef MSHR_STALL_STATS_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      ent_zero;
    logic                  push_fire;
    logic                  pop_fire;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign empty      = (wr_ptr == rd_ptr);
    assign count      = wr_ptr - rd_ptr;
    assign push_ready = !full;
    assign pop_valid  = !empty && ent_zero[rd_idx];
    assign pop_data   = mem[rd_idx];

    // A flush in the same cycle swallows any handshake.
    assign push_fire = push_valid && push_ready && !flush;
    assign pop_fire  = pop_valid && pop_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PW'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_idx] <= push_data;
    end

    // Push and pop never target the same slot: that needs full or empty.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        mshr_lat_cnt #(.LAT_WIDTH(LAT_WIDTH)) u_cnt (
            .clk   (clk),
            .load  (push_fire && (wr_idx == AW'(i))),
            .lat   (push_lat),
            .clear (rst || flush || (pop_fire && (rd_idx == AW'(i)))),
            .zero  (ent_zero[i])
        );
    end

`ifdef MSHR_STALL_STATS_EN
    function automatic logic [15:0] inc_sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (push_valid && !push_ready) begin
            stall_cnt <= inc_sat(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_mshr_latency_queue.sv
// Directed self-checking bench for mshr_latency_queue (DEPTH=8, LAT_WIDTH=3).
module tb_mshr_latency_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [73:0] push_data;
    logic [2:0]  push_lat;
    logic        pop_valid;
    logic        pop_ready;
    logic [73:0] pop_data;
    logic        full;
    logic        empty;
    logic [3:0]  count;
`ifdef MSHR_STALL_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mshr_latency_queue dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .push_lat   (push_lat),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .full       (full),
        .empty      (empty),
        .count      (count)
`ifdef MSHR_STALL_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_state(input string tag);
        chk({tag, "_empty"}, 80'(empty), 80'd1);
        chk({tag, "_full"}, 80'(full), 80'd0);
        chk({tag, "_push_ready"}, 80'(push_ready), 80'd1);
        chk({tag, "_pop_valid"}, 80'(pop_valid), 80'd0);
        chk({tag, "_count"}, 80'(count), 80'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        push_data = '0; push_lat = '0;
        tick(); tick();
        rst = 1'b0;
        idle_state("reset");
`ifdef MSHR_STALL_STATS_EN
        chk("reset_stall_cnt", 80'(stall_cnt), 80'd0);
`endif

        // single record with latency 3
        push_valid = 1'b1; push_data = 74'h1; push_lat = 3'd3;
        tick();
        push_valid = 1'b0; push_lat = 3'd0;
        for (int k = 0; k < 3; k++) begin
            chk("lat3_wait_pop_valid", 80'(pop_valid), 80'd0);
            chk("lat3_wait_count", 80'(count), 80'd1);
            tick();
        end
        chk("lat3_pop_valid", 80'(pop_valid), 80'd1);
        chk("lat3_pop_data", 80'(pop_data), 80'h1);
        chk("lat3_count", 80'(count), 80'd1);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        idle_state("lat3_after_pop");

        // fill to full, ninth push ignored, drain in order
        for (int i = 0; i < 8; i++) begin
            push_valid = 1'b1; push_data = 74'(32'h10 + i);
            tick();
        end
        chk("fill_full", 80'(full), 80'd1);
        chk("fill_push_ready", 80'(push_ready), 80'd0);
        chk("fill_count", 80'(count), 80'd8);
        push_data = 74'hFF;
        tick();
        push_valid = 1'b0;
        chk("ninth_count", 80'(count), 80'd8);
        pop_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_pop_valid", 80'(pop_valid), 80'd1);
            chk("drain_pop_data", 80'(pop_data), 80'(32'h10 + i));
            tick();
        end
        pop_ready = 1'b0;
        idle_state("drain_done");

        // slow head blocks a ready second entry
        push_valid = 1'b1; push_data = 74'hA0; push_lat = 3'd7;
        tick();
        push_data = 74'hB0; push_lat = 3'd0;
        tick();
        push_valid = 1'b0; pop_ready = 1'b1;
        for (int k = 1; k < 7; k++) begin
            chk("order_wait_pop_valid", 80'(pop_valid), 80'd0);
            chk("order_wait_count", 80'(count), 80'd2);
            tick();
        end
        chk("order_head_valid", 80'(pop_valid), 80'd1);
        chk("order_head_data", 80'(pop_data), 80'hA0);
        tick();
        chk("order_second_valid", 80'(pop_valid), 80'd1);
        chk("order_second_data", 80'(pop_data), 80'hB0);
        tick();
        pop_ready = 1'b0;
        idle_state("order_done");

        // full with simultaneous push and pop: no bypass
        for (int i = 0; i < 8; i++) begin
            push_valid = 1'b1; push_data = 74'(32'h20 + i);
            tick();
        end
        push_data = 74'h99; pop_ready = 1'b1;
        tick();
        chk("nobypass_count", 80'(count), 80'd7);
        chk("nobypass_full", 80'(full), 80'd0);
        tick();
        chk("pushpop_count", 80'(count), 80'd7);
        push_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("pushpop_drain_data", 80'(pop_data), (i < 6) ? 80'(32'h22 + i) : 80'h99);
            tick();
        end
        pop_ready = 1'b0;
        idle_state("pushpop_done");

        // flush with pending entries and a simultaneous push
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1; push_data = 74'(32'h30 + i); push_lat = 3'd5;
            tick();
        end
        flush = 1'b1; push_data = 74'h77;
        tick();
        flush = 1'b0; push_valid = 1'b0; push_lat = 3'd0;
        idle_state("flush");
        push_valid = 1'b1; push_data = 74'h55;
        tick();
        push_valid = 1'b0;
        chk("post_flush_count", 80'(count), 80'd1);
        chk("post_flush_data", 80'(pop_data), 80'h55);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;

        // streaming with three in flight: pointers wrap repeatedly
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1; push_data = 74'(32'h100 + i);
            tick();
        end
        pop_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_data = 74'(32'h103 + i);
            chk("wrap_pop_valid", 80'(pop_valid), 80'd1);
            chk("wrap_pop_data", 80'(pop_data), 80'(32'h100 + i));
            chk("wrap_count", 80'(count), 80'd3);
            tick();
        end
        push_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wrap_tail_data", 80'(pop_data), 80'(32'h128 + i));
            tick();
        end
        pop_ready = 1'b0;
        idle_state("wrap_done");

        // reset mid-countdown abandons pending records
        push_valid = 1'b1; push_data = 74'h66; push_lat = 3'd4;
        tick();
        push_valid = 1'b0; push_lat = 3'd0; rst = 1'b1;
        tick();
        rst = 1'b0; pop_ready = 1'b1;
        idle_state("rst_mid");
        for (int k = 0; k < 6; k++) tick();
        chk("rst_mid_later_pop_valid", 80'(pop_valid), 80'd0);
        chk("rst_mid_later_count", 80'(count), 80'd0);
        pop_ready = 1'b0;

`ifdef MSHR_STALL_STATS_EN
        chk("stats_after_rst", 80'(stall_cnt), 80'd0);
        for (int i = 0; i < 8; i++) begin
            push_valid = 1'b1; push_data = 74'(i);
            tick();
        end
        chk("stats_no_stall_yet", 80'(stall_cnt), 80'd0);
        tick(); tick(); tick();
        push_valid = 1'b0;
        chk("stats_three_stalls", 80'(stall_cnt), 80'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("stats_survive_flush", 80'(stall_cnt), 80'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
